// File: rtl/jmb_mul_arb_if.sv
// ---------------------------------------------------------------------------
// jmb_mul_arb_if
// Bundle of request/result signals between multiply clients and the shared
// multiplier arbiter jmb_mul_arb.
//   req_valid [NUM_REQ]    per-requester operand pair valid
//   req_a     [16*NUM_REQ] packed multiplicands, requester i at [16i+15:16i]
//   req_b     [16*NUM_REQ] packed multipliers, same packing
//   req_ready [NUM_REQ]    one-hot accept back to the requesters
//   res_valid              product valid
//   res_id    [ID_W]       requester that owns res_prod
//   res_prod  [32]         unsigned product
//   res_ready              consumer accepts the product
//   busy                   arbiter is not idle
// master: client/consumer side; slave: the arbiter.
// ---------------------------------------------------------------------------
interface jmb_mul_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  res_valid;
    logic [ID_W-1:0]       res_id;
    logic [31:0]           res_prod;
    logic                  res_ready;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_id, res_prod, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_id, res_prod, busy
    );
endinterface

// File: rtl/jmb_mul_arb.sv
// ---------------------------------------------------------------------------
// jmb_mul2 / jmb_mul_arb
// jmb_mul2: shared 16x16 unsigned combinational multiplier.
//   a_i, b_i [16] operands; p_o [32] full-width product.
// jmb_mul_arb: round-robin arbiter that time-shares one jmb_mul2 among
// NUM_REQ requesters. One operand pair is accepted at a time, held stable on
// the multiplier for MUL_LAT cycles (multicycle path), and the product is
// returned tagged with the requester ID on a backpressured result port.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    jmb_mul_arb_if.slave (request, result and busy signals)
// ---------------------------------------------------------------------------
module jmb_mul2 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [31:0] p_o
);
    assign p_o = 32'(a_i) * 32'(b_i);
endmodule

module jmb_mul_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    jmb_mul_arb_if.slave    bus
);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    // Request vector padded to the full ID range so an ID_W-bit index is exact.
    localparam int NSLOT = 1 << ID_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [ID_W-1:0]  last_q,      last_d;
    logic [ID_W-1:0]  id_q,        id_d;
    logic [15:0]      a_q,         a_d;
    logic [15:0]      b_q,         b_d;
    logic             res_valid_q, res_valid_d;
    logic [ID_W-1:0]  res_id_q,    res_id_d;
    logic [31:0]      res_prod_q,  res_prod_d;

    logic [NSLOT-1:0] vld_ext;
    logic [NSLOT-1:0] ready_ext;
    logic             any_req;
    logic [ID_W-1:0]  winner;
    logic [31:0]      prod;

    // First set request strictly after 'last', wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [NSLOT-1:0] vld,
        input logic [ID_W-1:0]  last
    );
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] pick;
        logic            found;
        idx   = last;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
            if (!found && vld[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        vld_ext              = '0;
        vld_ext[NUM_REQ-1:0] = bus.req_valid;
    end

    assign any_req = |bus.req_valid;
    assign winner  = rr_pick(vld_ext, last_q);

    // Grant is combinational in IDLE only; forced low while reset is asserted.
    always_comb begin
        ready_ext = '0;
        if (rst_n && (state_q == S_IDLE) && any_req) begin
            ready_ext[winner] = 1'b1;
        end
    end

    assign bus.req_ready = ready_ext[NUM_REQ-1:0];

    // Latched operands drive the multiplier for the whole BUSY period.
    jmb_mul2 u_mul (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (prod)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_prod_d  = res_prod_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    a_d     = bus.req_a[winner*16 +: 16];
                    b_d     = bus.req_b[winner*16 +: 16];
                    id_d    = winner;
                    last_d  = winner;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    res_prod_d  = prod;
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                // Result fields stay as they are after acceptance.
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_q      <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_prod_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_prod_q  <= res_prod_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_prod  = res_prod_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_jmb_mul_arb.sv
// ---------------------------------------------------------------------------
// tb_jmb_mul_arb
// Bench for jmb_mul_arb: a MUL_LAT=1 instance exercised from a vector table,
// random operations against a round-robin reference model, backpressure and
// mid-operation reset; a MUL_LAT=3 instance for the multicycle latency case.
// ---------------------------------------------------------------------------
module tb_jmb_mul_arb;
    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;
    int model_last;

    jmb_mul_arb_if #(.NUM_REQ(4), .ID_W(2)) if1 ();
    jmb_mul_arb_if #(.NUM_REQ(4), .ID_W(2)) if3 ();

    jmb_mul_arb #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    jmb_mul_arb #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        logic [63:0] a;
        logic [63:0] b;
        int          id;
        logic [31:0] prod;
        int          bp;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference arbitration: first valid requester after the previous winner.
    function automatic int rr_model(input logic [3:0] mask, input int last);
        logic [3:0] m;
        for (int k = 1; k <= 4; k++) begin
            m = mask >> ((last + k) % 4);
            if (m[0]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // One complete transaction on the MUL_LAT=1 instance; called right after
    // a falling edge with the DUT idle.
    task automatic run_op(input logic [3:0] mask, input logic [63:0] a, input logic [63:0] b,
                          input int exp_id, input logic [31:0] exp_prod, input int bp);
        if1.req_valid = mask;
        if1.req_a     = a;
        if1.req_b     = b;
        if1.res_ready = 1'b0;
        #2;
        check("grant", 64'(if1.req_ready), 64'(1) << exp_id);
        check("busy_idle", 64'(if1.busy), 64'(0));
        @(posedge clk);
        #1;
        if1.req_valid = '0;
        if1.req_a     = ~a;
        if1.req_b     = ~b;
        @(negedge clk);
        check("busy_run", 64'(if1.busy), 64'(1));
        check("early_valid", 64'(if1.res_valid), 64'(0));
        check("ready_run", 64'(if1.req_ready), 64'(0));
        @(negedge clk);
        check("res_valid", 64'(if1.res_valid), 64'(1));
        check("res_prod", 64'(if1.res_prod), 64'(exp_prod));
        check("res_id", 64'(if1.res_id), 64'(exp_id));
        for (int i = 0; i < bp; i++) begin
            if1.req_valid = 4'hF;
            #2;
            check("bp_ready", 64'(if1.req_ready), 64'(0));
            @(negedge clk);
            check("bp_valid", 64'(if1.res_valid), 64'(1));
            check("bp_prod", 64'(if1.res_prod), 64'(exp_prod));
            check("bp_id", 64'(if1.res_id), 64'(exp_id));
        end
        if1.req_valid = '0;
        if1.res_ready = 1'b1;
        @(posedge clk);
        #1;
        if1.res_ready = 1'b0;
        @(negedge clk);
        check("acc_valid", 64'(if1.res_valid), 64'(0));
        check("acc_busy", 64'(if1.busy), 64'(0));
        check("acc_prod_kept", 64'(if1.res_prod), 64'(exp_prod));
    endtask

    // At most one grant bit on either instance at any sample point.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (!$onehot0(if1.req_ready) || !$onehot0(if3.req_ready)) begin
                n_fail++;
                $display("FAIL onehot: actual=%b/%b required=onehot0", if1.req_ready, if3.req_ready);
            end
        end
    end

    initial begin
        logic [3:0]  mask;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] t;
        logic [31:0] p;
        int          w;

        n_checks = 0;
        n_fail   = 0;

        tbl[0] = '{4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd2}}, 0, 32'd2, 0};
        tbl[1] = '{4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd2}}, 1, 32'd4, 0};
        tbl[2] = '{4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd2}}, 2, 32'd6, 0};
        tbl[3] = '{4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd2}}, 3, 32'd8, 0};
        tbl[4] = '{4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd2}}, 0, 32'd2, 0};
        tbl[5] = '{4'b0001, {48'd0, 16'd3}, {48'd0, 16'd5}, 0, 32'd15, 5};
        tbl[6] = '{4'b0100, {16'd0, 16'hFFFF, 32'd0}, {16'd0, 16'hFFFF, 32'd0}, 2, 32'hFFFE0001, 1};
        tbl[7] = '{4'b1000, 64'd0, {16'hFFFF, 48'd0}, 3, 32'd0, 0};
        tbl[8] = '{4'b0110, {32'd0, 16'h1234, 16'd0}, {32'd0, 16'h5678, 16'd0}, 1, 32'h06260060, 2};

        rst_n         = 1'b0;
        if1.req_valid = 4'hF;
        if1.req_a     = '0;
        if1.req_b     = '0;
        if1.res_ready = 1'b0;
        if3.req_valid = '0;
        if3.req_a     = '0;
        if3.req_b     = '0;
        if3.res_ready = 1'b0;

        #7;
        check("rst_ready", 64'(if1.req_ready), 64'(0));
        check("rst_valid", 64'(if1.res_valid), 64'(0));
        check("rst_prod", 64'(if1.res_prod), 64'(0));
        check("rst_id", 64'(if1.res_id), 64'(0));
        check("rst_busy", 64'(if1.busy), 64'(0));
        check("rst_valid3", 64'(if3.res_valid), 64'(0));
        if1.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].mask, tbl[i].a, tbl[i].b, tbl[i].id, tbl[i].prod, tbl[i].bp);
        end
        model_last = tbl[8].id;

        // Multicycle latency with operands changed after acceptance.
        if3.req_valid = 4'b0010;
        if3.req_a     = {32'd0, 16'd100, 16'd0};
        if3.req_b     = {32'd0, 16'd7, 16'd0};
        #2;
        check("l3_grant", 64'(if3.req_ready), 64'(4'b0010));
        @(posedge clk);
        #1;
        if3.req_valid = '0;
        if3.req_a     = {4{16'hFFFF}};
        if3.req_b     = {4{16'hFFFF}};
        @(negedge clk);
        check("l3_busy", 64'(if3.busy), 64'(1));
        check("l3_e0", 64'(if3.res_valid), 64'(0));
        @(negedge clk);
        check("l3_e1", 64'(if3.res_valid), 64'(0));
        @(negedge clk);
        check("l3_e2", 64'(if3.res_valid), 64'(0));
        @(negedge clk);
        check("l3_e3", 64'(if3.res_valid), 64'(1));
        check("l3_prod", 64'(if3.res_prod), 64'(700));
        check("l3_id", 64'(if3.res_id), 64'(1));
        if3.res_ready = 1'b1;
        @(posedge clk);
        #1;
        if3.res_ready = 1'b0;
        @(negedge clk);
        check("l3_acc", 64'(if3.res_valid), 64'(0));
        check("l3_idle", 64'(if3.busy), 64'(0));

        // Random operations checked against the reference model.
        for (int n = 0; n < 40; n++) begin
            mask = 4'($urandom_range(1, 15));
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            w    = rr_model(mask, model_last);
            t    = ra >> (16 * w);
            p    = 32'(t[15:0]);
            t    = rb >> (16 * w);
            p    = p * 32'(t[15:0]);
            run_op(mask, ra, rb, w, p, int'($urandom_range(0, 3)));
            model_last = w;
        end

        // Reset while an operation is in flight.
        if1.req_valid = 4'hF;
        if1.req_a     = {4{16'd50}};
        if1.req_b     = {4{16'd60}};
        w = rr_model(4'hF, model_last);
        #2;
        check("mr_grant", 64'(if1.req_ready), 64'(1) << w);
        @(posedge clk);
        @(negedge clk);
        check("mr_busy_pre", 64'(if1.busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", 64'(if1.res_valid), 64'(0));
        check("mr_busy", 64'(if1.busy), 64'(0));
        check("mr_ready", 64'(if1.req_ready), 64'(0));
        check("mr_prod", 64'(if1.res_prod), 64'(0));
        @(negedge clk);
        check("mr_still_idle", 64'(if1.res_valid), 64'(0));
        rst_n = 1'b1;
        model_last = 3;
        run_op(4'hF, {4{16'd9}}, {4{16'd11}}, 0, 32'd99, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jmb_mul_arb.md
Name: jmb_mul_arb

Overview:
Round-robin arbiter and sequencer that shares one instance of the team's 16x16 unsigned multiplier (jmb_mul2) among NUM_REQ requesters. It accepts one operand pair at a time via valid/ready, holds the operands for MUL_LAT cycles, and presents the 32-bit product tagged with the requester ID on a backpressured result port. It sits between the multiply clients and the shared jmb_mul2 instance, which it instantiates internally.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
ID_W, 2, width of requester ID; NUM_REQ <= 2**ID_W is required.
MUL_LAT, 1, cycles operands are held before the product is captured (>=1). This allows multicycle timing on the multiplier path.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_a  in  16*NUM_REQ  packed multiplicand; requester i uses bits [16i+15:16i].
req_b  in  16*NUM_REQ  packed multiplier, same packing.
req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit high.
res_valid  out  1  result valid.
res_id  out  ID_W  index of the requester that owns res_prod.
res_prod  out  32  unsigned product a*b.
res_ready  in  1  consumer accepts result.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; res_valid=0; res_prod=0; res_id=0; cnt=0; last_grant=NUM_REQ-1, so requester 0 has top priority first. req_ready=0 while rst_n=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req_ready is combinational. If any req_valid is set, the winner is the first set bit scanning last_grant+1, last_grant+2, ... mod NUM_REQ. Only req_ready[winner]=1.
  - At the clock edge with a request: latch a, b and id; set last_grant=winner; cnt=MUL_LAT-1; go to BUSY.
  - With no request: stay in IDLE and set all req_ready=0.
- BUSY:
  - req_ready=0.
  - The latched a and b drive the jmb_mul2 instance.
  - If cnt==0 at an edge: res_prod<=product, res_id<=latched id, res_valid<=1, go to DONE. Otherwise cnt<=cnt-1.
- DONE:
  - req_ready=0. res_valid, res_id and res_prod are held stable.
  - At an edge with res_ready=1: res_valid<=0, go to IDLE. res_prod and res_id keep their last values.
- Latency: accept edge E0 gives res_valid=1 after edge E0+MUL_LAT.
- Throughput: at best one op per MUL_LAT+2 cycles. There is no grant in the same cycle as result acceptance.
- Arithmetic: unsigned, full 32-bit result, no truncation or saturation.
- Requester rules:
  - A requester must hold req_valid, req_a and req_b stable until it sees req_ready.
  - Dropping req_valid before it is granted is legal; that requester is simply skipped.
  - req_a/req_b changes after the accept edge have no effect on the op in flight.
- Reset mid-operation (BUSY or DONE): the op is discarded, there is no result, and all outputs return to reset values immediately.
- res_ready while res_valid=0 is ignored.
- busy = (state != IDLE), registered-state decode.

Test Plan:
- Single op, NUM_REQ=4, MUL_LAT=1: req_valid=0001, a0=3, b0=5 -> req_ready=0001 in IDLE cycle; res_valid=1 one edge after accept with res_prod=15 and res_id=0; res_ready=1 -> IDLE, busy=0.
- Round robin: all four req_valid held high, res_ready=1, a_i=i+1, b_i=2 -> grant order 0,1,2,3,0, products 2,4,6,8,2 with matching res_id; never two req_ready bits set.
- Backpressure: result valid with res_ready=0 for 5 cycles -> res_valid, res_prod and res_id stable; no req_ready while waiting; accepted on the first res_ready=1 edge.
- Max operands: a=0xFFFF, b=0xFFFF -> res_prod=0xFFFE0001; a=0, b=0xFFFF -> 0.
- MUL_LAT=3: accept at edge E0 -> res_valid rises after E3, not earlier; changing req_a after E0 does not alter the result.
- Reset mid-op: rst_n=0 during BUSY -> res_valid=0, busy=0 immediately. After release, the next grant goes to requester 0 when all requesters are valid.
